// File: rtl/arm_hazard_if.sv
// Decode-to-hazard-unit bus: decoded operand/destination info in, stall/forward/halt control out.
// fsm_state mirrors the drain FSM (0 RUN, 1 DRAIN, 2 HALT) for observation.
interface arm_hazard_if;
    logic       id_valid;
    logic [2:0] id_read_mask;
    logic [3:0] id_read_reg0;
    logic [3:0] id_read_reg1;
    logic [3:0] id_read_reg2;
    logic       id_rd_we;
    logic [3:0] id_rd_num;
    logic       id_is_load;
    logic       id_cpsr_we;
    logic       id_cond_use;
    logic       id_halt;
    logic       stall;
    logic [1:0] fwd_sel0;
    logic [1:0] fwd_sel1;
    logic [1:0] fwd_sel2;
    logic       halted;
    logic [1:0] fsm_state;

    // Decode side drives the instruction fields; the hazard unit answers in the same cycle.
    // There is no handshake: stall=1 means decode must hold its instruction for another cycle.
    modport master (
        output id_valid, id_read_mask, id_read_reg0, id_read_reg1, id_read_reg2,
               id_rd_we, id_rd_num, id_is_load, id_cpsr_we, id_cond_use, id_halt,
        input  stall, fwd_sel0, fwd_sel1, fwd_sel2, halted, fsm_state
    );
    modport slave (
        input  id_valid, id_read_mask, id_read_reg0, id_read_reg1, id_read_reg2,
               id_rd_we, id_rd_num, id_is_load, id_cpsr_we, id_cond_use, id_halt,
        output stall, fwd_sel0, fwd_sel1, fwd_sel2, halted, fsm_state
    );
endinterface

// File: rtl/arm_hazard_unit.sv
// ARM pipeline hazard unit: shadow EX/MEM/WB tracking, stall, operand forwarding, SWI drain/halt.
// Define HAZARD_FORWARDING_EN to forward from EX/MEM/WB; otherwise any dependency stalls until WB retires.
module arm_hazard_unit (
    input  logic         clk,
    input  logic         rst,
    arm_hazard_if.slave  hz
);
    typedef struct packed {
        logic       valid;
        logic       rd_we;
        logic [3:0] rd_num;
        logic       is_load;
        logic       cpsr_we;
    } stage_t;

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;

    state_t     state, state_nxt;
    stage_t     ex_q, mem_q, wb_q, ex_d;
    logic [3:0] rd_reg [3];
    logic [2:0] hit_ex, hit_mem, hit_wb;
    logic [1:0] fwd [3];
    logic       flag_haz, data_haz, stall, issue;

    function automatic logic stage_hit(stage_t s, logic m, logic [3:0] r);
        // R15 reads come from the PC path, never from an in-flight writer.
        return s.valid && s.rd_we && m && (r != 4'd15) && (s.rd_num == r);
    endfunction

    assign rd_reg[0] = hz.id_read_reg0;
    assign rd_reg[1] = hz.id_read_reg1;
    assign rd_reg[2] = hz.id_read_reg2;

    always_comb begin
        hit_ex  = '0;
        hit_mem = '0;
        hit_wb  = '0;
        for (int i = 0; i < 3; i++) begin
            hit_ex[i]  = stage_hit(ex_q,  hz.id_read_mask[i], rd_reg[i]);
            hit_mem[i] = stage_hit(mem_q, hz.id_read_mask[i], rd_reg[i]);
            hit_wb[i]  = stage_hit(wb_q,  hz.id_read_mask[i], rd_reg[i]);
        end
    end

    assign flag_haz = hz.id_cond_use && ex_q.valid && ex_q.cpsr_we;

`ifdef HAZARD_FORWARDING_EN
    // Only a load in EX cannot be forwarded: its data is not available until MEM.
    assign data_haz = ex_q.is_load && (|hit_ex);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            fwd[i] = 2'b00;
            if (hz.id_valid) begin
                if (hit_ex[i])       fwd[i] = 2'b01;
                else if (hit_mem[i]) fwd[i] = 2'b10;
                else if (hit_wb[i])  fwd[i] = 2'b11;
            end
        end
    end
`else
    assign data_haz = |(hit_ex | hit_mem | hit_wb);

    always_comb begin
        for (int i = 0; i < 3; i++) fwd[i] = 2'b00;
    end
`endif

    always_comb begin
        stall     = 1'b1;
        state_nxt = state;
        case (state)
            RUN: begin
                stall = hz.id_valid && (data_haz || flag_haz);
                if (hz.id_valid && hz.id_halt && !stall) state_nxt = DRAIN;
            end
            // EX only ever receives bubbles here, so WB is empty next cycle once EX and MEM are.
            DRAIN: if (!ex_q.valid && !mem_q.valid) state_nxt = HALT;
            HALT:  state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    assign issue = (state == RUN) && hz.id_valid && !stall;

    always_comb begin
        ex_d = '0;
        if (issue) begin
            ex_d.valid   = 1'b1;
            ex_d.rd_we   = hz.id_rd_we;
            ex_d.rd_num  = hz.id_rd_num;
            ex_d.is_load = hz.id_is_load;
            ex_d.cpsr_we = hz.id_cpsr_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            state <= state_nxt;
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{ex_q.is_load, mem_q.is_load, mem_q.cpsr_we, wb_q.is_load, wb_q.cpsr_we};

    assign hz.stall     = stall;
    assign hz.fwd_sel0  = fwd[0];
    assign hz.fwd_sel1  = fwd[1];
    assign hz.fwd_sel2  = fwd[2];
    assign hz.halted    = (state == HALT);
    assign hz.fsm_state = state;
endmodule

// File: tb/tb_arm_hazard_unit.sv
// Bench for arm_hazard_unit: directed ARM sequences plus random traffic, scored against a
// list-of-in-flight-writers reference model through an expected-output queue.
module tb_arm_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  arm_hazard_if bus ();

  arm_hazard_unit dut (.clk(clk), .rst(rst), .hz(bus.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [2:0] mask;
    logic [3:0] r0, r1, r2;
    logic       rd_we;
    logic [3:0] rd;
    logic       is_load, cpsr_we, cond_use, halt;
  } instr_t;

  typedef struct packed {
    logic       valid;
    logic       rd_we;
    logic [3:0] rd;
    logic       is_load;
    logic       cpsr_we;
  } slot_t;

  // Reference model: in-flight instructions, index 0 = youngest (EX), 2 = oldest (WB).
  slot_t pipe [3];
  int    mode;        // 0 running, 1 draining after SWI, 2 halted
  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic instr_t mk(logic [2:0] mask, int r0, int r1, int r2, logic we, int rd,
                                logic ld, logic cw, logic cu, logic h);
    instr_t t;
    t.valid = 1'b1; t.mask = mask;
    t.r0 = 4'(r0); t.r1 = 4'(r1); t.r2 = 4'(r2);
    t.rd_we = we; t.rd = 4'(rd); t.is_load = ld; t.cpsr_we = cw; t.cond_use = cu; t.halt = h;
    return t;
  endfunction

  function automatic logic [7:0] model_expect(instr_t in);
    logic [3:0] regs [3];
    logic [1:0] fsel [3];
    logic dep_any, load_use, flag, hazard, st;
    int youngest;
    regs[0] = in.r0; regs[1] = in.r1; regs[2] = in.r2;
    dep_any = 1'b0; load_use = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fsel[i] = 2'b00;
      youngest = -1;
      // scan oldest to youngest so the last writer found is the youngest
      for (int j = 2; j >= 0; j--)
        if (in.valid && in.mask[i] && regs[i] != 4'd15 && pipe[j].valid && pipe[j].rd_we
            && pipe[j].rd == regs[i])
          youngest = j;
      if (youngest >= 0) begin
        dep_any = 1'b1;
        if (youngest == 0 && pipe[0].is_load) load_use = 1'b1;
        fsel[i] = 2'(youngest + 1);
      end
    end
`ifdef HAZARD_FORWARDING_EN
    hazard = load_use;
`else
    hazard = dep_any;
    for (int i = 0; i < 3; i++) fsel[i] = 2'b00;
`endif
    flag = in.cond_use && pipe[0].valid && pipe[0].cpsr_we;
    st = (mode != 0) ? 1'b1 : (in.valid && (hazard || flag));
    return {(mode == 2), st, fsel[0], fsel[1], fsel[2]};
  endfunction

  task automatic model_advance(instr_t in, logic st);
    logic issue;
    int old_mode;
    issue = (mode == 0) && in.valid && !st;
    old_mode = mode;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = issue ? {1'b1, in.rd_we, in.rd, in.is_load, in.cpsr_we} : '0;
    if (old_mode == 1 && !pipe[0].valid && !pipe[1].valid && !pipe[2].valid) mode = 2;
    else if (old_mode == 0 && issue && in.halt) mode = 1;
  endtask

  task automatic drive(instr_t in);
    bus.id_valid = in.valid;       bus.id_read_mask = in.mask;
    bus.id_read_reg0 = in.r0;      bus.id_read_reg1 = in.r1;   bus.id_read_reg2 = in.r2;
    bus.id_rd_we = in.rd_we;       bus.id_rd_num = in.rd;      bus.id_is_load = in.is_load;
    bus.id_cpsr_we = in.cpsr_we;   bus.id_cond_use = in.cond_use; bus.id_halt = in.halt;
  endtask

  // One clock of stimulus, entered and left on a falling edge.
  task automatic do_cycle(instr_t in, output logic st);
    logic [7:0] e;
    drive(in);
    e = model_expect(in);
    exp_q.push_back(e);
    st = e[6];
    model_advance(in, e[6]);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    logic st;
    for (int k = 0; k < n; k++) do_cycle('0, st);
  endtask

  // Decode holds an instruction until the model says it is accepted (bounded).
  task automatic issue(instr_t in);
    logic st;
    for (int k = 0; k < 16; k++) begin
      do_cycle(in, st);
      if (!st) break;
    end
  endtask

  task automatic do_reset();
    drive('0);
    rst = 1'b1;
    for (int j = 0; j < 3; j++) pipe[j] = '0;
    mode = 0;
    exp_q.push_back(8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic instr_t rand_instr();
    instr_t t;
    t.valid = ($urandom_range(0, 5) != 0);
    t.mask = 3'($urandom_range(0, 7));
    t.r0 = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
    t.r1 = 4'($urandom_range(0, 7));
    t.r2 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
    t.rd_we = ($urandom_range(0, 3) != 0);
    t.rd = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
    t.is_load = ($urandom_range(0, 2) == 0);
    t.cpsr_we = ($urandom_range(0, 3) == 0);
    t.cond_use = ($urandom_range(0, 3) == 0);
    t.halt = ($urandom_range(0, 60) == 0);
    return t;
  endfunction

  // Monitor: outputs are presented every cycle; sample mid-low-phase, away from the rising edge.
  initial begin
    logic [7:0] act, exp_v;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act = {bus.halted, bus.stall, bus.fwd_sel0, bus.fwd_sel1, bus.fwd_sel2};
        checks++;
        if (act !== exp_v) begin
          errors++;
          $display("FAIL outputs cycle %0d: got halted=%b stall=%b fwd=%b/%b/%b, expected halted=%b stall=%b fwd=%b/%b/%b",
                   cyc, act[7], act[6], act[5:4], act[3:2], act[1:0],
                   exp_v[7], exp_v[6], exp_v[5:4], exp_v[3:2], exp_v[1:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic st;
    instr_t t;
    drive('0);
    for (int j = 0; j < 3; j++) pipe[j] = '0;
    mode = 0;
    @(negedge clk);
    do_reset();

    // ADD r1 ; ADD r2,r1,r3
    issue(mk(3'b000, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    issue(mk(3'b011, 1, 3, 0, 1, 2, 0, 0, 0, 0));
    idle(4);
    // LDR r4 ; ADD r5,r4,r6
    issue(mk(3'b001, 0, 0, 0, 1, 4, 1, 0, 0, 0));
    issue(mk(3'b011, 4, 6, 0, 1, 5, 0, 0, 0, 0));
    idle(4);
    // SUBS ; ADDEQ
    issue(mk(3'b001, 2, 0, 0, 1, 8, 0, 1, 0, 0));
    issue(mk(3'b001, 9, 0, 0, 1, 10, 0, 0, 1, 0));
    idle(4);
    // r7 writers in WB and EX, then a reader of r7 on operand 2
    issue(mk(3'b000, 0, 0, 0, 1, 7, 0, 0, 0, 0));
    issue(mk(3'b000, 0, 0, 0, 1, 3, 0, 0, 0, 0));
    issue(mk(3'b000, 0, 0, 0, 1, 7, 0, 0, 0, 0));
    issue(mk(3'b100, 0, 0, 7, 1, 11, 0, 0, 0, 0));
    idle(4);
    // R15 writer then R15 reader: never a dependency
    issue(mk(3'b000, 0, 0, 0, 1, 15, 1, 0, 0, 0));
    issue(mk(3'b111, 15, 15, 15, 1, 1, 0, 0, 0, 0));
    idle(4);
    // ADD ; ADD ; SWI, then drain into halt and stay there
    issue(mk(3'b000, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    issue(mk(3'b000, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    issue(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    idle(5);
    for (int k = 0; k < 3; k++) do_cycle(mk(3'b001, 1, 0, 0, 1, 3, 0, 0, 0, 0), st);
    do_reset();
    // reset in the middle of a drain
    issue(mk(3'b000, 0, 0, 0, 1, 5, 0, 0, 0, 0));
    issue(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    idle(1);
    do_reset();
    issue(mk(3'b001, 5, 0, 0, 1, 6, 0, 0, 0, 0));
    idle(3);

    // random traffic; a halted pipeline is reset after a few cycles
    for (int n = 0; n < 800; n++) begin
      t = rand_instr();
      if (mode == 2 && $urandom_range(0, 3) == 0) do_reset();
      else if (t.valid && $urandom_range(0, 1) == 0) issue(t);
      else do_cycle(t, st);
    end
    idle(2);
    @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/arm_hazard_unit.md
ARM_HAZARD_UNIT -- requirements
Module: arm_hazard_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: id_valid  in  1  decode stage holds a real instruction (condition passed).
REQ-004 SHALL have: id_read_mask  in  3  per-operand "register actually read" flags from decode.
REQ-005 SHALL have: id_read_reg0/1/2  in  4 each  source register numbers; ignored where mask bit is 0.
REQ-006 SHALL have: id_rd_we, id_rd_num  in  1/4  decoded destination write enable and number.
REQ-007 SHALL have: id_is_load  in  1  destination data comes from memory.
REQ-008 SHALL have: id_cpsr_we, id_cond_use  in  1/1  writes flags; condition field is not AL.
REQ-009 SHALL have: id_halt  in  1  decoded SWI.
REQ-010 SHALL have: stall  out  1  hold PC and IF/ID register this cycle.
REQ-011 SHALL have: fwd_sel0/1/2  out  2 each  operand source: 00 regfile, 01 EX, 10 MEM, 11 WB.
REQ-012 SHALL have: halted  out  1  pipeline drained after SWI.

Function
REQ-013 SHALL keep a shadow pipeline of stages EX, MEM, WB, each holding valid, rd_we, rd_num, is_load, cpsr_we.
REQ-014 Every cycle MEM<=EX and WB<=MEM; EX<=decode fields when id_valid and not stall, else EX<=bubble (valid 0).
REQ-015 A stage "hits" operand i when stage valid, rd_we, rd_num==id_read_regi and id_read_mask[i]=1.
REQ-016 Load-use: EX load hitting any read operand SHALL assert stall combinationally for exactly that cycle.
REQ-017 Flag hazard: id_cond_use with EX cpsr_we valid SHALL assert stall.
REQ-018 fwd_selI SHALL select the youngest hitting stage (EX over MEM over WB); no hit -> 00.
REQ-019 Register 15 SHALL never hit; fwd_sel for R15 operands is 00.
REQ-020 Stall and fwd_sel SHALL be 0/00 when id_valid=0.
REQ-021 FSM states RUN, DRAIN, HALT; RUN->DRAIN when id_valid, id_halt and not stall.
REQ-022 In DRAIN, stall=1 and EX receives bubbles; DRAIN->HALT when EX, MEM, WB all invalid.
REQ-023 HALT is terminal until reset; halted=1 only in HALT; stall=1 in DRAIN and HALT.
REQ-024 Simultaneous load-use and flag hazard SHALL produce a single stall cycle per blocking condition, not additive.

Reset
REQ-025 On rst: all stage valids 0, FSM RUN, stall 0, halted 0, all fwd_sel 00, effective immediately.
REQ-026 Reset asserted mid-DRAIN SHALL return to RUN with empty shadow pipeline.

Configuration
REQ-027 Macro HAZARD_FORWARDING_EN defined: forwarding per REQ-016..REQ-018.
REQ-028 Macro undefined: fwd_sel tied 00; any hit in EX, MEM or WB SHALL stall until the writer leaves WB.

Verification
REQ-029 ADD r1 then ADD r2,r1,r3 back-to-back -> no stall, fwd_sel0=01; without macro, 3 stall cycles.
REQ-030 LDR r4 then ADD r5,r4,r6 -> stall 1 cycle, then fwd_sel0=10.
REQ-031 SUBS then ADDEQ next -> stall 1 cycle; ADDEQ issues after SUBS leaves EX.
REQ-032 Writers to r7 in EX and WB, reader of r7 -> fwd_sel=01 (youngest wins).
REQ-033 SWI after two ADDs -> stall from SWI, halted=1 exactly when EX/MEM/WB empty (3 cycles later).
REQ-034 rst pulsed during DRAIN -> halted=0, stall=0, fwd_sel 00 same cycle, FSM RUN.
